// File: rtl/sysarr_output_drain.sv
// Double-buffered capture of systolic-array result rows, drained in row order
// through a valid/ready write-back port.
module sysarr_output_drain #(
  parameter int N  = 4,
  parameter int DW = 16,
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              out_en,
  input  logic [RW-1:0]     row_out,
  input  logic [DW*N-1:0]   array_output,
  input  logic              clr,
  output logic              stall,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [RW-1:0]     wr_row,
  output logic [DW*N-1:0]   wr_data,
  output logic              wr_last,
  output logic              mat_done,
  output logic              err_dup,
  output logic              err_ovf
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [RW:0]   NROWS = (RW+1)'(N);
  localparam logic [RW-1:0] LAST  = RW'(N-1);

  logic [DW*N-1:0] mem_q [2][N];
  logic [1:0][N-1:0] mask_q, mask_d;
  logic [1:0]        full_q, full_d;
  logic              fill_ptr_q, fill_ptr_d;
  logic              drain_ptr_q, drain_ptr_d;
  state_t            state_q, state_d;
  logic [RW-1:0]     cnt_q, cnt_d;
  logic              mat_done_q, mat_done_d;
  logic              err_dup_q, err_dup_d;
  logic              err_ovf_q, err_ovf_d;

  logic [N-1:0] fill_mask;
  logic [N-1:0] row_bit;
  logic         row_seen;
  logic         take;
  logic         cap;

  assign stall     = full_q[fill_ptr_q];
  assign fill_mask = mask_q[fill_ptr_q];
  assign row_bit   = {{(N-1){1'b0}}, 1'b1} << row_out;
  // Out-of-range indices are folded into the duplicate path so they never write.
  assign row_seen  = ({1'b0, row_out} < NROWS) ? |(fill_mask & row_bit) : 1'b1;
  assign take      = out_en && !stall;
  assign cap       = take && !row_seen && !clr;

  always_comb begin
    mask_d      = mask_q;
    full_d      = full_q;
    fill_ptr_d  = fill_ptr_q;
    drain_ptr_d = drain_ptr_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    mat_done_d  = 1'b0;
    err_dup_d   = err_dup_q | (take && row_seen);
    err_ovf_d   = err_ovf_q | (out_en && stall);

    if (cap) begin
      mask_d[fill_ptr_q] = fill_mask | row_bit;
      if (&(fill_mask | row_bit)) begin
        full_d[fill_ptr_q] = 1'b1;
        fill_ptr_d         = ~fill_ptr_q;
        mat_done_d         = 1'b1;
      end
    end

    // Drain never targets the bank being filled: a full drain bank stalls capture.
    case (state_q)
      IDLE: begin
        if (full_q[drain_ptr_q]) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (wr_ready) begin
          if (cnt_q == LAST) begin
            mask_d[drain_ptr_q] = '0;
            full_d[drain_ptr_q] = 1'b0;
            drain_ptr_d         = ~drain_ptr_q;
            state_d             = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      mask_d      = '0;
      full_d      = '0;
      fill_ptr_d  = 1'b0;
      drain_ptr_d = 1'b0;
      state_d     = IDLE;
      cnt_d       = '0;
      mat_done_d  = 1'b0;
      err_dup_d   = err_dup_q;
      err_ovf_d   = err_ovf_q;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      mask_q      <= '0;
      full_q      <= '0;
      fill_ptr_q  <= 1'b0;
      drain_ptr_q <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      mat_done_q  <= 1'b0;
      err_dup_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      full_q      <= full_d;
      fill_ptr_q  <= fill_ptr_d;
      drain_ptr_q <= drain_ptr_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mat_done_q  <= mat_done_d;
      err_dup_q   <= err_dup_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) mem_q[fill_ptr_q][row_out] <= array_output;
  end

  assign wr_valid = (state_q == SEND);
  assign wr_row   = wr_valid ? cnt_q : '0;
  assign wr_data  = wr_valid ? mem_q[drain_ptr_q][cnt_q] : '0;
  assign wr_last  = wr_valid && (cnt_q == LAST);
  assign mat_done = mat_done_q;
  assign err_dup  = err_dup_q;
  assign err_ovf  = err_ovf_q;

endmodule

// File: tb/tb_sysarr_output_drain.sv
// Scoreboard bench for sysarr_output_drain: stimulus pushes expected write-back
// rows, a negedge monitor pops and compares on every accepted transfer.
module tb_sysarr_output_drain;

  localparam int N  = 4;
  localparam int DW = 16;

  typedef struct {
    logic [1:0]  row;
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic          clk = 1'b0;
  logic          nRST;
  logic          out_en;
  logic [1:0]    row_out;
  logic [63:0]   array_output;
  logic          clr;
  logic          stall;
  logic          wr_valid;
  logic          wr_ready;
  logic [1:0]    wr_row;
  logic [63:0]   wr_data;
  logic          wr_last;
  logic          mat_done;
  logic          err_dup;
  logic          err_ovf;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int md_cnt = 0;
  logic        hold_chk = 1'b0;
  logic [1:0]  hold_row;
  logic [63:0] hold_data;

  sysarr_output_drain #(.N(N), .DW(DW)) dut (
    .clk(clk), .nRST(nRST), .out_en(out_en), .row_out(row_out),
    .array_output(array_output), .clr(clr), .stall(stall),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row),
    .wr_data(wr_data), .wr_last(wr_last), .mat_done(mat_done),
    .err_dup(err_dup), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: transfer happens at the next rising edge when valid & ready here.
  always @(negedge clk) begin
    if (nRST) begin
      if (mat_done) md_cnt++;
      if (hold_chk) begin
        check("hold_row", 64'(wr_row), 64'(hold_row));
        check("hold_data", wr_data, hold_data);
      end
      hold_chk  = wr_valid && !wr_ready;
      hold_row  = wr_row;
      hold_data = wr_data;
      if (wr_valid && wr_ready) begin
        if (q.size() == 0) begin
          check("unexpected_row", 64'(wr_row), 64'hFFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("wb_row", 64'(wr_row), 64'(e.row));
          check("wb_data", wr_data, e.data);
          check("wb_last", 64'(wr_last), 64'(e.last));
        end
      end
    end else begin
      hold_chk = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int r, input logic [63:0] d);
    exp_t e;
    e.row  = 2'(r);
    e.data = d;
    e.last = (r == N-1);
    q.push_back(e);
  endtask

  task automatic send_row(input int r, input logic [63:0] d);
    out_en       = 1'b1;
    row_out      = 2'(r);
    array_output = d;
    tick();
    out_en       = 1'b0;
    array_output = '0;
  endtask

  // rows[64*r +: 64] is row r; ord[2*i +: 2] is the i-th row presented.
  task automatic send_mat(input logic [255:0] rows, input logic [7:0] ord);
    for (int i = 0; i < N; i++) begin
      int r;
      r = int'(ord[2*i +: 2]);
      send_row(r, rows[64*r +: 64]);
    end
    for (int r = 0; r < N; r++) push_exp(r, rows[64*r +: 64]);
  endtask

  task automatic wait_empty(input int maxc);
    int i;
    for (i = 0; i < maxc && (q.size() != 0 || wr_valid); i++) tick();
    check("drain_pending", 64'(q.size()), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_stall"}, 64'(stall), 64'd0);
    check({tag, "_wr_valid"}, 64'(wr_valid), 64'd0);
    check({tag, "_wr_row"}, 64'(wr_row), 64'd0);
    check({tag, "_wr_data"}, wr_data, 64'd0);
    check({tag, "_wr_last"}, 64'(wr_last), 64'd0);
    check({tag, "_mat_done"}, 64'(mat_done), 64'd0);
    check({tag, "_err_dup"}, 64'(err_dup), 64'd0);
    check({tag, "_err_ovf"}, 64'(err_ovf), 64'd0);
  endtask

  localparam logic [255:0] MAT_A = {64'h4444444444444444, 64'h3333333333333333,
                                    64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] MAT_B = {64'h8888888888888888, 64'h7777777777777777,
                                    64'h6666666666666666, 64'h5555555555555555};
  localparam logic [255:0] MAT_T = {64'h0004000400040004, 64'h0003000300030003,
                                    64'h0002000200020002, 64'h0001000100010001};
  localparam logic [255:0] MAT_E = {64'hE3E3E3E3E3E3E3E3, 64'hE2E2E2E2E2E2E2E2,
                                    64'hE1E1E1E1E1E1E1E1, 64'hE0E0E0E0E0E0E0E0};
  localparam logic [255:0] MAT_F = {64'hF3F3F3F3F3F3F3F3, 64'hF2F2F2F2F2F2F2F2,
                                    64'hF1F1F1F1F1F1F1F1, 64'hF0F0F0F0F0F0F0F0};
  localparam logic [255:0] MAT_G = {64'h0D0D0D0D0D0D0D0D, 64'h0C0C0C0C0C0C0C0C,
                                    64'h0B0B0B0B0B0B0B0B, 64'h0A0A0A0A0A0A0A0A};
  localparam logic [7:0] ORD_INORDER = {2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [7:0] ORD_2031    = {2'd1, 2'd3, 2'd0, 2'd2};

  initial begin
    int md0;
    logic [3:0] pat;
    nRST = 1'b0; out_en = 1'b0; row_out = '0; array_output = '0;
    clr = 1'b0; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    nRST = 1'b1;
    tick();

    // In-order matrix, ready high; check capture-to-valid latency.
    md_cnt = 0;
    send_mat(MAT_A, ORD_INORDER);
    check("lat_mat_done", 64'(mat_done), 64'd1);
    check("lat_valid_k", 64'(wr_valid), 64'd0);
    tick();
    check("lat_valid_k1", 64'(wr_valid), 64'd1);
    check("lat_row0", 64'(wr_row), 64'd0);
    wait_empty(20);
    check("mat_done_once", 64'(md_cnt), 64'd1);

    // Out-of-order capture, in-order write-back.
    send_mat(MAT_B, ORD_2031);
    wait_empty(20);

    // Duplicate row 1: first data kept, completion waits for row 3.
    check("dup_pre", 64'(err_dup), 64'd0);
    md0 = md_cnt;
    send_row(0, 64'h9999999999999999);
    send_row(1, 64'hAAAAAAAAAAAAAAAA);
    send_row(1, 64'hDEADDEADDEADDEAD);
    check("dup_flag", 64'(err_dup), 64'd1);
    send_row(2, 64'hBBBBBBBBBBBBBBBB);
    tick();
    check("dup_not_done", 64'(md_cnt), 64'(md0));
    send_row(3, 64'hCCCCCCCCCCCCCCCC);
    push_exp(0, 64'h9999999999999999);
    push_exp(1, 64'hAAAAAAAAAAAAAAAA);
    push_exp(2, 64'hBBBBBBBBBBBBBBBB);
    push_exp(3, 64'hCCCCCCCCCCCCCCCC);
    wait_empty(20);
    check("dup_done", 64'(md_cnt), 64'(md0 + 1));

    // Back-pressure pattern 1,0,0,1 during SEND.
    send_mat(MAT_T, ORD_INORDER);
    pat = 4'b1001;
    for (int i = 0; i < 16; i++) begin
      wr_ready = pat[3 - (i % 4)];
      tick();
    end
    wr_ready = 1'b1;
    wait_empty(20);

    // Overflow: two matrices fill both banks, ninth row dropped.
    wr_ready = 1'b0;
    send_mat(MAT_A, ORD_INORDER);
    check("ovf_stall_a", 64'(stall), 64'd0);
    send_mat(MAT_B, ORD_INORDER);
    check("ovf_stall_b", 64'(stall), 64'd1);
    check("ovf_pre", 64'(err_ovf), 64'd0);
    send_row(0, 64'h0C0C0C0C0C0C0C0C);
    check("ovf_flag", 64'(err_ovf), 64'd1);
    check("ovf_stall_hold", 64'(stall), 64'd1);
    wr_ready = 1'b1;
    for (int i = 0; i < 20 && stall; i++) tick();
    check("ovf_stall_fall", 64'(stall), 64'd0);
    check("ovf_b_left", 64'(q.size()), 64'd4);
    wait_empty(30);

    // clr discards a partial matrix and keeps the sticky errors.
    send_row(0, 64'h5A5A5A5A5A5A5A5A);
    send_row(1, 64'h5A5A5A5A5A5A5A5A);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_err_dup", 64'(err_dup), 64'd1);
    check("clr_err_ovf", 64'(err_ovf), 64'd1);
    send_mat(MAT_E, ORD_2031);
    wait_empty(20);

    // Reset while row 2 is being offered.
    wr_ready = 1'b0;
    send_mat(MAT_F, ORD_INORDER);
    tick();
    wr_ready = 1'b1;
    tick();
    tick();
    wr_ready = 1'b0;
    check("rst_mid_row", 64'(wr_row), 64'd2);
    check("rst_mid_valid", 64'(wr_valid), 64'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk_zero("rst_mid");
    q.delete();
    tick();
    nRST = 1'b1;
    wr_ready = 1'b1;
    tick();
    send_mat(MAT_G, ORD_INORDER);
    wait_empty(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
